spmv_comparator: RTL and testbench

- Row-index lookup for a CSR sparse matrix-vector multiply engine.
- Takes a 1-based running nonzero-element counter (count) and the packed CSR row-pointer array (row_ptr, 17 entries for 16 rows).
- Returns the row index that element belongs to (reg_addr), registered, for addressing the row accumulator/result register file.
- Sits between the nonzero-element counter and the per-row accumulator registers.

---
 rtl/spmv_comparator.sv | 52 +++++
 tb/tb_spmv_comparator.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/spmv_comparator.sv
// spmv_comparator
//   Row-index lookup for a CSR sparse matrix-vector multiply engine. Given the
//   1-based running nonzero counter and the packed CSR row-pointer array, it
//   returns, one cycle later, the row that owns that nonzero element.
//
// Ports
//   i_clk    in   clock, rising-edge active
//   i_rstn   in   asynchronous active-low reset
//   count    in   [PTR_W-1:0]            1-based nonzero element index
//   row_ptr  in   [(ROWS+1)*PTR_W-1:0]   packed CSR pointers, entry 0 in LSBs
//   reg_addr out  [$clog2(ROWS)-1:0]     registered owning row index
module spmv_comparator #(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned PTR_W = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [PTR_W-1:0]              count,
    input  logic [(ROWS+1)*PTR_W-1:0]     row_ptr,
    output logic [$clog2(ROWS)-1:0]       reg_addr
);

    localparam int unsigned AW = $clog2(ROWS);

    logic [AW-1:0] next_addr;

    // The final pointer only bounds the last row; ownership is decided by the
    // lower ROWS entries alone.
    logic unused_last_ptr;
    assign unused_last_ptr = ^row_ptr[ROWS*PTR_W +: PTR_W];

    // Highest entry strictly below count wins. Later iterations overwrite
    // earlier ones, so empty rows (equal consecutive pointers) are skipped
    // naturally in favour of the last row sharing that pointer value.
    always_comb begin
        next_addr = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (row_ptr[i*PTR_W +: PTR_W] < count) begin
                next_addr = i[AW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            reg_addr <= '0;
        end else begin
            reg_addr <= next_addr;
        end
    end

endmodule

// File: tb/tb_spmv_comparator.sv
// tb_spmv_comparator
//   Self-checking bench for spmv_comparator: directed CSR cases, boundary
//   counts, async reset behaviour, and randomized pointer arrays checked
//   against a row-ownership reference model.
module tb_spmv_comparator;

    logic         i_clk;
    logic         i_rstn;
    logic [7:0]   count;
    logic [135:0] row_ptr;
    logic [3:0]   reg_addr;

    int tests;
    int fails;

    spmv_comparator #(.ROWS(16), .PTR_W(8)) dut (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .count    (count),
        .row_ptr  (row_ptr),
        .reg_addr (reg_addr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Row r owns elements row_ptr[r]+1 .. row_ptr[r+1]; the owner of element
    // c is the last row whose starting pointer lies below c (row 0 if none).
    function automatic int owner_row(input logic [135:0] p, input logic [7:0] c);
        int unsigned starts[16];
        int owner;
        for (int r = 0; r < 16; r++) starts[r] = p[8*r +: 8];
        owner = 0;
        for (int r = 15; r >= 0; r--) begin
            if (starts[r] < c) begin
                owner = r;
                break;
            end
        end
        return owner;
    endfunction

    // Drive away from the active edge, then sample 1 time unit after it.
    task automatic step(input logic [7:0] c, input logic [135:0] p);
        @(negedge i_clk);
        count   = c;
        row_ptr = p;
        @(posedge i_clk);
        #1;
    endtask

    task automatic step_check(input string tag, input logic [7:0] c,
                              input logic [135:0] p, input int exp);
        step(c, p);
        check_eq(tag, int'(reg_addr), exp);
        check_eq({tag, "_model"}, owner_row(p, c), exp);
    endtask

    localparam logic [135:0] SWEEP_PTR = 136'h0a_09_09_09_07_07_07_07_04_04_04_03_02_02_01_00_00;

    initial begin
        logic [135:0] p;
        logic [7:0]   c;
        int           sweep_exp [10];
        byte unsigned vals [17];

        tests = 0;
        fails = 0;
        sweep_exp = '{1, 2, 4, 5, 8, 8, 8, 12, 12, 15};

        // Reset held for three cycles with arbitrary inputs.
        i_rstn  = 1'b0;
        count   = 8'd5;
        row_ptr = SWEEP_PTR;
        #1;
        check_eq("reset_immediate", int'(reg_addr), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk);
            #1;
            check_eq("reset_hold", int'(reg_addr), 0);
        end
        @(negedge i_clk);
        i_rstn = 1'b1;

        // Sweep table.
        for (int k = 1; k <= 10; k++) begin
            c = 8'(k);
            step_check("sweep", c, SWEEP_PTR, sweep_exp[k-1]);
        end

        // Bounds on the same pointers.
        step_check("bound_cnt0",   8'd0,   SWEEP_PTR, 0);
        step_check("bound_cnt11",  8'd11,  SWEEP_PTR, 15);
        step_check("bound_cnt255", 8'd255, SWEEP_PTR, 15);

        // Dense diagonal: one nonzero per row.
        for (int i = 0; i <= 16; i++) p[8*i +: 8] = 8'(i);
        for (int k = 1; k <= 16; k++) begin
            c = 8'(k);
            step_check("diag", c, p, k - 1);
        end

        // All nonzeros in the last row.
        p = '0;
        p[128 +: 8] = 8'd8;
        for (int k = 1; k <= 8; k++) begin
            c = 8'(k);
            step_check("last_row", c, p, 15);
        end

        // All nonzeros in the first row.
        for (int i = 1; i <= 16; i++) p[8*i +: 8] = 8'd8;
        p[7:0] = 8'd0;
        for (int k = 1; k <= 8; k++) begin
            c = 8'(k);
            step_check("first_row", c, p, 0);
        end

        // Async reset mid-sweep while the output sits at row 8.
        step_check("pre_async", 8'd5, SWEEP_PTR, 8);
        @(negedge i_clk);
        #2;
        i_rstn = 1'b0;
        #1;
        check_eq("async_assert", int'(reg_addr), 0);
        @(posedge i_clk);
        #1;
        check_eq("async_held", int'(reg_addr), 0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        step_check("async_resume", 8'd10, SWEEP_PTR, 15);

        // Randomized: monotonic CSR arrays on even trials, arbitrary on odd.
        for (int t = 0; t < 300; t++) begin
            if (t % 2 == 0) begin
                vals[0] = 8'd0;
                for (int i = 1; i <= 16; i++) begin
                    int unsigned nxt;
                    nxt = int'(vals[i-1]) + $urandom_range(0, 4);
                    vals[i] = (nxt > 255) ? 8'd255 : 8'(nxt);
                end
            end else begin
                for (int i = 0; i <= 16; i++) vals[i] = 8'($urandom_range(0, 255));
            end
            for (int i = 0; i <= 16; i++) p[8*i +: 8] = vals[i];
            c = (t % 2 == 0) ? 8'($urandom_range(0, int'(vals[16]) + 2))
                             : 8'($urandom_range(0, 255));
            step(c, p);
            check_eq("random", int'(reg_addr), owner_row(p, c));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
